// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder
//
// Instruction-memory responder for a fetch stage. A request is accepted
// in IDLE, waits WAIT_STATES cycles, then returns the addressed word with
// a one-cycle ready pulse. A branch-taken flush cancels an in-flight fetch.
// The word storage can be written at any time through the load port
// (program load); a word written before the response cycle is returned.
//
// Parameters:
//   WAIT_STATES  idle cycles between acceptance and data return (0..15)
//   DEPTH_WORDS  storage depth in 32-bit words (power of two)
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   req          fetch request, held high until ready
//   address      byte address of the requested instruction
//   flush        cancel any in-flight fetch
//   load_en      storage write strobe
//   load_addr    byte address for storage write
//   load_data    word to write
//   instruction  returned word; holds its value between responses
//   ready        one-cycle pulse, instruction valid this cycle
//   freeze       stall to fetch stage (req & ~ready, low during flush)

`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 32
`endif

module inst_fetch_responder #(
    parameter int WAIT_STATES = 2,
    parameter int DEPTH_WORDS = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req,
    input  logic [`ADDRESS_LEN-1:0]     address,
    input  logic                        flush,
    input  logic                        load_en,
    input  logic [`ADDRESS_LEN-1:0]     load_addr,
    input  logic [`INSTRUCTION_LEN-1:0] load_data,
    output logic [`INSTRUCTION_LEN-1:0] instruction,
    output logic                        ready,
    output logic                        freeze
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [3:0]                    count;
    logic [3:0]                    count_next;
    logic [IDX_W-1:0]              index;
    logic [IDX_W-1:0]              index_next;
    logic [`INSTRUCTION_LEN-1:0]   last_instruction;
    logic [`INSTRUCTION_LEN-1:0]   storage [DEPTH_WORDS];

    logic [IDX_W-1:0]              req_index;
    logic [IDX_W-1:0]              load_index;
    logic                          unused_addr_bits;

    // Byte addresses wrap modulo the storage size; only the word index is used.
    assign req_index  = address[IDX_W+1:2];
    assign load_index = load_addr[IDX_W+1:2];
    assign unused_addr_bits = ^{address[`ADDRESS_LEN-1:IDX_W+2], address[1:0],
                                load_addr[`ADDRESS_LEN-1:IDX_W+2], load_addr[1:0]};

    // Next-state logic. Counter holds the remaining wait cycles; the
    // transition to RESP is taken when it reaches 1 so that total latency
    // from acceptance to ready is WAIT_STATES+1 cycles.
    always_comb begin
        state_next = state;
        count_next = count;
        index_next = index;
        case (state)
            IDLE: begin
                if (req && !flush) begin
                    index_next = req_index;
                    count_next = WAIT_INIT;
                    state_next = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    count_next = count - 4'd1;
                    if (count <= 4'd1) begin
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Ready and the returned word are combinational in the RESP cycle so a
    // load written during WAIT is seen, while a load in the RESP cycle only
    // lands at the closing edge.
    always_comb begin
        ready       = (state == RESP) && !flush && !rst;
        instruction = ready ? storage[index] : last_instruction;
        freeze      = req && !ready && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            count            <= 4'd0;
            index            <= '0;
            last_instruction <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            index <= index_next;
            if (ready) begin
                last_instruction <= storage[index];
            end
        end
    end

    // Storage is deliberately not cleared by reset; loads are blocked during reset.
    always_ff @(posedge clk) begin
        if (!rst && load_en) begin
            storage[load_index] <= load_data;
        end
    end

endmodule

// File: doc/inst_fetch_responder.md
INST_FETCH_RESPONDER -- requirements
Module: inst_fetch_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2: idle cycles between request acceptance and data return (legal range 0..15).
REQ-002 Parameter DEPTH_WORDS, default 64: storage depth in 32-bit words; power of two.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 req  in  1  fetch request from the fetch stage; held high until ready.
REQ-006 address  in  `ADDRESS_LEN  byte address of the requested instruction.
REQ-007 flush  in  1  branch-taken cancel; aborts any in-flight fetch.
REQ-008 load_en  in  1  storage write strobe (program load).
REQ-009 load_addr  in  `ADDRESS_LEN  byte address for load write.
REQ-010 load_data  in  `INSTRUCTION_LEN  word to write.
REQ-011 instruction  out  `INSTRUCTION_LEN  returned instruction word.
REQ-012 ready  out  1  one-cycle pulse; instruction valid this cycle.
REQ-013 freeze  out  1  stall to fetch stage: high while req is high and ready is low.

Function
REQ-014 Word index = address[log2(DEPTH_WORDS)+1:2]; bits [1:0] and bits above the index are ignored (address wraps modulo DEPTH_WORDS*4).
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 IDLE: on req=1 and flush=0, latch index, load wait counter with WAIT_STATES, go to WAIT (or RESP if WAIT_STATES=0).
REQ-017 WAIT: counter decrements each cycle; at counter=1 transition to RESP next cycle; total latency from acceptance edge to ready = WAIT_STATES+1 cycles.
REQ-018 RESP: ready=1 for exactly one cycle, instruction = storage[latched index] read in that cycle; next state IDLE.
REQ-019 Back-to-back: req still high in the cycle after RESP is accepted as a new request from IDLE (one idle bubble between responses).
REQ-020 flush=1 in WAIT or RESP: return to IDLE next cycle; ready is forced 0 in that cycle; no response for the aborted fetch.
REQ-021 flush=1 and req=1 in IDLE: request not accepted; stay IDLE.
REQ-022 req dropping to 0 in WAIT without flush: fetch completes normally; ready still pulses.
REQ-023 load_en=1: storage[load index] <= load_data at the edge, in any state; load index formed per REQ-014.
REQ-024 Load to the latched index while in WAIT: response returns the newly written word; load in the RESP cycle itself is not visible until the next read.
REQ-025 instruction holds its last returned value when ready=0; changes only on ready cycles.
REQ-026 freeze is combinational: req & ~ready; freeze=0 whenever flush=1.

Reset
REQ-027 rst=1 at an edge: state IDLE, counter 0, latched index 0, instruction 32'h0, ready 0; storage contents not cleared.
REQ-028 rst overrides flush, req and in-flight fetches; a fetch in WAIT is discarded with no ready pulse.
REQ-029 load_en is ignored while rst=1.

Verification
REQ-030 Load word 0x4 = 32'hE3A01005, rst low, req=1 address=0x4, WAIT_STATES=2 -> ready pulses on the 3rd edge after acceptance with instruction=32'hE3A01005; freeze=1 for the 3 prior cycles.
REQ-031 WAIT_STATES=0, req held high over addresses 0x0,0x4 -> ready every other cycle, correct words, freeze low in ready cycles.
REQ-032 req accepted, flush=1 on first WAIT cycle -> no ready pulse, state IDLE, instruction unchanged; new req at 0x8 then returns storage[2].
REQ-033 Address 0x103 with DEPTH_WORDS=64 -> returns storage[0] (wrap, low bits ignored).
REQ-034 During WAIT write load_addr=latched address with 32'hDEADBEEF -> response is 32'hDEADBEEF.
REQ-035 rst asserted mid-WAIT -> next cycle IDLE, ready=0, instruction=0, storage contents preserved on subsequent read.
